spi_master: RTL and testbench

SPI_MASTER -- requirements
Module: spi_master

---
 rtl/spi_pkg.sv | 20 ++
 rtl/spi_clk_gen.sv | 27 ++
 rtl/spi_master.sv | 143 ++++++++++++++
 tb/tb_spi_master.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI master: FSM states, mode bit
// positions and the four standard SPI mode encodings.
package spi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LEAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_TRAIL = 2'd3
  } spi_state_t;

  localparam int CPOL_BIT = 1;
  localparam int CPHA_BIT = 0;

  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

endpackage

// File: rtl/spi_clk_gen.sv
// Half-period tick generator: pulses o_tick every CLK_DIV enabled cycles,
// restarting from zero whenever i_clr is asserted.
module spi_clk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tick
);

  logic [7:0] r_cnt;

  assign o_tick = i_en && (r_cnt == 8'(CLK_DIV - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_clr || !i_en || o_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

endmodule

// File: rtl/spi_master.sv
// Single-byte SPI master, all four modes, LSB-first transmit and MSB-first
// receive assembly; every output is driven from a register.
module spi_master
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] mode,
  input  logic [7:0] tx_data,
  input  logic       miso,
  output logic       sclk,
  output logic       mosi,
  output logic       cs,
  output logic [7:0] rx_data,
  output logic       busy,
  output logic       done
);

  spi_state_t r_state, w_state_next;

  logic [1:0] r_mode;
  logic [7:0] r_tx;
  logic [7:0] r_rx_shift;
  logic [7:0] r_rx;
  logic [3:0] r_half;
  logic       r_sclk;
  logic       r_mosi;
  logic       r_cs;
  logic       r_busy;
  logic       r_done;

  logic       w_tick;
  logic       w_state_change;
  logic       w_edge;
  logic [3:0] w_h_next;
  logic       w_leading;
  logic       w_cpha;
  logic [2:0] w_bit_lead;
  logic [2:0] w_bit_trail;

  assign w_state_change = (w_state_next != r_state);

  spi_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
    .clk    (clk),
    .reset  (reset),
    .i_clr  (w_state_change),
    .i_en   (r_state != ST_IDLE),
    .o_tick (w_tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (start) w_state_next = ST_LEAD;
      ST_LEAD:  if (w_tick) w_state_next = ST_SHIFT;
      ST_SHIFT: if (w_tick && (r_half == 4'd15)) w_state_next = ST_TRAIL;
      ST_TRAIL: if (w_tick) w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  // An sclk edge opens each of the 16 SHIFT half-periods; even ones are leading.
  assign w_edge      = w_tick && ((r_state == ST_LEAD) ||
                                  ((r_state == ST_SHIFT) && (r_half != 4'd15)));
  assign w_h_next    = (r_state == ST_LEAD) ? 4'd0 : (r_half + 4'd1);
  assign w_leading   = ~w_h_next[0];
  assign w_cpha      = r_mode[CPHA_BIT];
  assign w_bit_lead  = w_h_next[3:1];
  assign w_bit_trail = w_h_next[3:1] + 3'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mode     <= MODE0;
      r_tx       <= '0;
      r_rx_shift <= '0;
      r_rx       <= '0;
      r_half     <= '0;
      r_sclk     <= 1'b0;
      r_mosi     <= 1'b0;
      r_cs       <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_mode     <= mode;
            r_tx       <= tx_data;
            r_sclk     <= mode[CPOL_BIT];
            r_cs       <= 1'b0;
            r_busy     <= 1'b1;
            r_half     <= '0;
            r_rx_shift <= '0;
            if (!mode[CPHA_BIT]) r_mosi <= tx_data[0];
          end
        end
        ST_LEAD, ST_SHIFT: begin
          if (w_edge) begin
            r_half <= w_h_next;
            r_sclk <= ~r_sclk;
            if (w_leading ^ w_cpha) r_rx_shift <= {r_rx_shift[6:0], miso};
            if (w_cpha && w_leading) begin
              r_mosi <= r_tx[w_bit_lead];
            end else if (!w_cpha && !w_leading && (w_h_next != 4'd15)) begin
              r_mosi <= r_tx[w_bit_trail];
            end
          end else if (w_tick) begin
            r_sclk <= r_mode[CPOL_BIT];
          end
        end
        ST_TRAIL: begin
          if (w_tick) begin
            r_done <= 1'b1;
            r_rx   <= r_rx_shift;
            r_cs   <= 1'b1;
            r_busy <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign sclk    = r_sclk;
  assign mosi    = r_mosi;
  assign cs      = r_cs;
  assign rx_data = r_rx;
  assign busy    = r_busy;
  assign done    = r_done;

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: table of single transfers plus hand-written
// busy-restart, back-to-back and mid-transfer reset sequences.
module tb_spi_master;

  localparam int CLK_DIV = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [1:0] mode;
  logic [7:0] tx_data;
  logic       miso;
  logic       sclk;
  logic       mosi;
  logic       cs;
  logic [7:0] rx_data;
  logic       busy;
  logic       done;

  always #5 clk = ~clk;

  spi_master #(.CLK_DIV(CLK_DIV)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .mode    (mode),
    .tx_data (tx_data),
    .miso    (miso),
    .sclk    (sclk),
    .mosi    (mosi),
    .cs      (cs),
    .rx_data (rx_data),
    .busy    (busy),
    .done    (done)
  );

  // Slave model: either loops mosi back or shifts slv_pat out MSB-first,
  // and captures mosi LSB-first on the master's sampling edge.
  logic       lb = 1'b1;
  logic       slv_bit = 1'b0;
  logic [7:0] slv_pat = 8'h00;
  logic [7:0] cap = 8'h00;
  logic       cur_cpol = 1'b0;
  logic       cur_cpha = 1'b0;
  logic       prev_sclk = 1'b0;
  logic       started = 1'b0;
  int         slv_idx = 7;

  assign miso = lb ? mosi : slv_bit;

  always @(negedge clk) begin
    if (cs) begin
      started   = 1'b0;
      prev_sclk = sclk;
    end else if (!started) begin
      started   = 1'b1;
      slv_idx   = 7;
      prev_sclk = sclk;
      if (!cur_cpha) slv_bit = slv_pat[7];
    end else if (sclk != prev_sclk) begin
      logic lead;
      lead      = (sclk != cur_cpol);
      prev_sclk = sclk;
      if (lead != cur_cpha) cap = {mosi, cap[7:1]};
      if (cur_cpha && lead && slv_idx >= 0) begin
        slv_bit = slv_pat[slv_idx];
        slv_idx = slv_idx - 1;
      end else if (!cur_cpha && !lead && slv_idx > 0) begin
        slv_idx = slv_idx - 1;
        slv_bit = slv_pat[slv_idx];
      end
    end
  end

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;
  int cyc = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (done) done_cnt <= done_cnt + 1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0] mode;
    logic [7:0] tx;
    logic       lb;
    logic [7:0] pat;
    logic [7:0] exp_rx;
  } vec_t;

  vec_t vecs[7];

  task automatic run_xfer(input vec_t v);
    int n;
    @(negedge clk);
    mode     = v.mode;
    tx_data  = v.tx;
    lb       = v.lb;
    slv_pat  = v.pat;
    cur_cpol = v.mode[1];
    cur_cpha = v.mode[0];
    start    = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    tx_data = ~v.tx;
    mode    = ~v.mode;
    chk("cs_low_T1", {31'd0, cs}, 32'd0);
    chk("busy_T1", {31'd0, busy}, 32'd1);
    chk("sclk_lead_idle", {31'd0, sclk}, {31'd0, v.mode[1]});
    if (!v.mode[0]) chk("mosi_bit0_T1", {31'd0, mosi}, {31'd0, v.tx[0]});
    n = 1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (!busy) break;
      n++;
    end
    chk("busy_cycles", n, 72);
    chk("done_pulse", {31'd0, done}, 32'd1);
    chk("cs_high_done", {31'd0, cs}, 32'd1);
    chk("rx_data", {24'd0, rx_data}, {24'd0, v.exp_rx});
    chk("sclk_idle", {31'd0, sclk}, {31'd0, v.mode[1]});
    chk("mosi_sent", {24'd0, cap}, {24'd0, v.tx});
    $display("[TB] xfer mode=%0d tx=%02h rx=%02h exp=%02h busy=%0d", v.mode, v.tx, rx_data, v.exp_rx, n);
    @(negedge clk);
    chk("done_single", {31'd0, done}, 32'd0);
    chk("rx_hold", {24'd0, rx_data}, {24'd0, v.exp_rx});
  endtask

  initial begin
    int d0;
    int t_a;
    int n;
    vec_t v;

    vecs[0] = '{mode: 2'b00, tx: 8'hA5, lb: 1'b1, pat: 8'h00, exp_rx: 8'hA5};
    vecs[1] = '{mode: 2'b01, tx: 8'h3C, lb: 1'b0, pat: 8'hC3, exp_rx: 8'hC3};
    vecs[2] = '{mode: 2'b10, tx: 8'h3C, lb: 1'b0, pat: 8'hC3, exp_rx: 8'hC3};
    vecs[3] = '{mode: 2'b11, tx: 8'h3C, lb: 1'b0, pat: 8'hC3, exp_rx: 8'hC3};
    vecs[4] = '{mode: 2'b00, tx: 8'h3C, lb: 1'b0, pat: 8'hC3, exp_rx: 8'hC3};
    vecs[5] = '{mode: 2'b11, tx: 8'h12, lb: 1'b1, pat: 8'h00, exp_rx: 8'h48};
    vecs[6] = '{mode: 2'b01, tx: 8'h01, lb: 1'b1, pat: 8'h00, exp_rx: 8'h80};

    reset   = 1'b1;
    start   = 1'b0;
    mode    = 2'b00;
    tx_data = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_cs", {31'd0, cs}, 32'd1);
    chk("rst_sclk", {31'd0, sclk}, 32'd0);
    chk("rst_mosi", {31'd0, mosi}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_rx", {24'd0, rx_data}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 7; i++) run_xfer(vecs[i]);

    // start and tx/mode changes while busy must be ignored
    d0 = done_cnt;
    @(negedge clk);
    mode = 2'b00; tx_data = 8'h1E; lb = 1'b1; cur_cpol = 1'b0; cur_cpha = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    start = 1'b1; tx_data = 8'hFF; mode = 2'b11;
    repeat (10) @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (!busy) break;
    end
    chk("ign_rx", {24'd0, rx_data}, 32'h78);
    chk("ign_cap", {24'd0, cap}, 32'h1E);
    repeat (3) @(negedge clk);
    chk("ign_done_count", done_cnt - d0, 1);
    chk("ign_idle", {31'd0, busy}, 32'd0);
    $display("[TB] ignore-while-busy tx=1e rx=%02h", rx_data);

    // back-to-back: second start presented in the done cycle
    @(negedge clk);
    mode = 2'b00; tx_data = 8'h01; lb = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (done) break;
    end
    t_a = cyc;
    chk("b2b_done1", {31'd0, done}, 32'd1);
    chk("b2b_cs_gap", {31'd0, cs}, 32'd1);
    chk("b2b_rx1", {24'd0, rx_data}, 32'h80);
    tx_data = 8'h80; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("b2b_cs_one_cycle", {31'd0, cs}, 32'd0);
    n = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (done) break;
      n++;
    end
    chk("b2b_done2", {31'd0, done}, 32'd1);
    chk("b2b_spacing", cyc - t_a, 73);
    chk("b2b_rx2", {24'd0, rx_data}, 32'h01);
    $display("[TB] back-to-back spacing=%0d rx2=%02h", cyc - t_a, rx_data);

    // reset in SHIFT at bit 4 aborts without done and clears rx_data
    @(negedge clk);
    mode = 2'b00; tx_data = 8'h3C; lb = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (36) @(negedge clk);
    chk("mid_busy", {31'd0, busy}, 32'd1);
    d0 = done_cnt;
    reset = 1'b1;
    #1;
    chk("mid_rst_cs", {31'd0, cs}, 32'd1);
    chk("mid_rst_sclk", {31'd0, sclk}, 32'd0);
    chk("mid_rst_mosi", {31'd0, mosi}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_done", {31'd0, done}, 32'd0);
    chk("mid_rst_rx", {24'd0, rx_data}, 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_no_done", done_cnt - d0, 0);
    $display("[TB] reset mid-transfer rx=%02h", rx_data);
    v = '{mode: 2'b00, tx: 8'hFF, lb: 1'b1, pat: 8'h00, exp_rx: 8'hFF};
    run_xfer(v);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
